// File: rtl/waveform_sequencer.sv
// Segment-table sequencer pacing sample requests into a counter + square-pulse generator chain.
// Build option: define SEQ_LOOP_EN to replay the table continuously instead of a single pass.
module waveform_sequencer #(
    parameter int N_FRAC  = 7,
    parameter int NUM_SEG = 4,
    parameter int LEN_W   = 8,
    parameter int DIV_W   = 8,
    parameter int TIMEOUT = 64,
    localparam int SEG_W  = $clog2(NUM_SEG),
    localparam int DW     = N_FRAC + 1,
    localparam int TMR_W  = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_we_i,
    input  logic [SEG_W-1:0]     cfg_addr_i,
    input  logic signed [DW-1:0] cfg_phase_i,
    input  logic signed [DW-1:0] cfg_amp_i,
    input  logic [LEN_W-1:0]     cfg_len_i,
    input  logic [DIV_W-1:0]     div_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 gen_valid_strobe_i,
    output logic signed [DW-1:0] phase_o,
    output logic signed [DW-1:0] amplitude_o,
    output logic                 next_data_strobe_o,
    output logic [SEG_W-1:0]     seg_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_t;

    state_t                state;
    logic signed [DW-1:0]  tbl_phase [NUM_SEG];
    logic signed [DW-1:0]  tbl_amp   [NUM_SEG];
    logic [LEN_W-1:0]      tbl_len   [NUM_SEG];
    logic [LEN_W-1:0]      remain;
    logic [DIV_W-1:0]      divcnt;
    logic [TMR_W-1:0]      timer;
    logic                  issued_any;
    logic                  last_seg;
    logic                  advance;

    assign last_seg = (seg_idx_o == SEG_W'(NUM_SEG - 1));

    // Segment finished: either an empty segment in LOAD or the final accepted sample in WAIT.
    always_comb begin
        advance = 1'b0;
        if (state == LOAD && tbl_len[seg_idx_o] == '0)
            advance = 1'b1;
        if (state == WAIT && gen_valid_strobe_i && remain == LEN_W'(1))
            advance = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                tbl_phase[i] <= '0;
                tbl_amp[i]   <= '0;
                tbl_len[i]   <= '0;
            end
        end else if (cfg_we_i) begin
            tbl_phase[cfg_addr_i] <= cfg_phase_i;
            tbl_amp[cfg_addr_i]   <= cfg_amp_i;
            tbl_len[cfg_addr_i]   <= cfg_len_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= IDLE;
            phase_o            <= '0;
            amplitude_o        <= '0;
            next_data_strobe_o <= 1'b0;
            seg_idx_o          <= '0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            err_o              <= 1'b0;
            remain             <= '0;
            divcnt             <= '0;
            timer              <= '0;
            issued_any         <= 1'b0;
        end else begin
            next_data_strobe_o <= 1'b0;
            done_o             <= 1'b0;
            if (stop_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            state      <= LOAD;
                            seg_idx_o  <= '0;
                            err_o      <= 1'b0;
                            busy_o     <= 1'b1;
                            issued_any <= 1'b0;
                        end
                    end
                    LOAD: begin
                        phase_o     <= tbl_phase[seg_idx_o];
                        amplitude_o <= tbl_amp[seg_idx_o];
                        remain      <= tbl_len[seg_idx_o];
                        divcnt      <= div_i;
                        state       <= ISSUE;
                    end
                    ISSUE: begin
                        if (divcnt != '0) begin
                            divcnt <= divcnt - 1'b1;
                        end else begin
                            next_data_strobe_o <= 1'b1;
                            issued_any         <= 1'b1;
                            timer              <= '0;
                            state              <= WAIT;
                        end
                    end
                    WAIT: begin
                        // A strobe in the final timeout cycle still counts as a response.
                        if (gen_valid_strobe_i) begin
                            remain <= remain - 1'b1;
                            divcnt <= div_i;
                            state  <= ISSUE;
                        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                            err_o  <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase

                if (advance) begin
                    if (!last_seg) begin
                        seg_idx_o <= seg_idx_o + 1'b1;
                        state     <= LOAD;
                    end else begin
`ifdef SEQ_LOOP_EN
                        // A pass that issued nothing would spin forever, so it ends the run.
                        if (issued_any) begin
                            seg_idx_o  <= '0;
                            issued_any <= 1'b0;
                            state      <= LOAD;
                        end else begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end
`else
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed bench for waveform_sequencer: request contents checked through a scoreboard queue.
module tb_waveform_sequencer;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              cfg_we_i = 1'b0;
    logic [1:0]        cfg_addr_i = '0;
    logic signed [7:0] cfg_phase_i = '0;
    logic signed [7:0] cfg_amp_i = '0;
    logic [7:0]        cfg_len_i = '0;
    logic [7:0]        div_i = '0;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic              gen_valid_strobe_i = 1'b0;
    logic signed [7:0] phase_o;
    logic signed [7:0] amplitude_o;
    logic              next_data_strobe_o;
    logic [1:0]        seg_idx_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    typedef struct {
        logic signed [7:0] ph;
        logic signed [7:0] amp;
        logic [1:0]        seg;
    } req_t;

    req_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    waveform_sequencer dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .cfg_we_i           (cfg_we_i),
        .cfg_addr_i         (cfg_addr_i),
        .cfg_phase_i        (cfg_phase_i),
        .cfg_amp_i          (cfg_amp_i),
        .cfg_len_i          (cfg_len_i),
        .div_i              (div_i),
        .start_i            (start_i),
        .stop_i             (stop_i),
        .gen_valid_strobe_i (gen_valid_strobe_i),
        .phase_o            (phase_o),
        .amplitude_o        (amplitude_o),
        .next_data_strobe_o (next_data_strobe_o),
        .seg_idx_o          (seg_idx_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ph, input int amp, input int seg);
        req_t e;
        e.ph  = ph[7:0];
        e.amp = amp[7:0];
        e.seg = seg[1:0];
        sb.push_back(e);
    endtask

    task automatic wr(input int a, input int ph, input int amp, input int len);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a[1:0];
        cfg_phase_i = ph[7:0];
        cfg_amp_i   = amp[7:0];
        cfg_len_i   = len[7:0];
        step();
        cfg_we_i = 1'b0;
    endtask

    task automatic pulse_start(output int t);
        t = cyc;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Wait (bounded) for a request pulse and compare it with the oldest expectation.
    task automatic get_req(input string tag, output int t);
        int n = 0;
        req_t e;
        while (next_data_strobe_o !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        t = cyc;
        check({tag, "_seen"}, next_data_strobe_o, 1);
        if (next_data_strobe_o === 1'b1) begin
            check({tag, "_sb_underflow"}, (sb.size() == 0), 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, "_phase"}, phase_o, e.ph);
                check({tag, "_amp"}, amplitude_o, e.amp);
                check({tag, "_seg"}, seg_idx_o, e.seg);
            end
        end
    endtask

    task automatic echo(input string tag);
        step();
        check({tag, "_strobe_1cyc"}, next_data_strobe_o, 0);
        gen_valid_strobe_i = 1'b1;
        step();
        gen_valid_strobe_i = 1'b0;
    endtask

    task automatic finish_pass(input string tag, input int n_skip);
        for (int i = 0; i < n_skip; i++) begin
            check({tag, "_done_early"}, done_o, 0);
            step();
        end
`ifdef SEQ_LOOP_EN
        check({tag, "_loop_no_done"}, done_o, 0);
        check({tag, "_loop_busy"}, busy_o, 1);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check({tag, "_stop_busy"}, busy_o, 0);
        check({tag, "_stop_done"}, done_o, 0);
`else
        check({tag, "_done"}, done_o, 1);
        check({tag, "_done_busy"}, busy_o, 0);
`endif
    endtask

    task automatic empty_pass(input string tag);
        int t0;
        pulse_start(t0);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_no_req"}, next_data_strobe_o, 0);
            check({tag, "_no_done"}, done_o, 0);
            step();
        end
        check({tag, "_done"}, done_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_no_req_end"}, next_data_strobe_o, 0);
        step();
        check({tag, "_done_pulse"}, done_o, 0);
    endtask

    initial begin
        int t0, t1, t2, t3;
        step();
        step();
        check("rst_phase", phase_o, 0);
        check("rst_amp", amplitude_o, 0);
        check("rst_seg", seg_idx_o, 0);
        check("rst_req", next_data_strobe_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        rst_i = 1'b0;
        step();

        // Empty table after reset: every segment skipped.
        empty_pass("empty");

        // Single segment, three paced requests.
        wr(0, 8, 0, 3);
        div_i = 8'd2;
        repeat (3) push(8, 0, 0);
        pulse_start(t0);
        get_req("t1r1", t1);
        check("t1_latency", t1 - t0, 5);
        echo("t1r1");
        get_req("t1r2", t2);
        check("t1_space12", t2 - t1, 5);
        echo("t1r2");
        get_req("t1r3", t3);
        check("t1_space23", t3 - t2, 5);
        echo("t1r3");
        finish_pass("t1", 3);

        // Two segments, amplitude extremes, no divider.
        wr(0, 8, -64, 2);
        wr(1, 8, 63, 1);
        div_i = 8'd0;
        push(8, -64, 0);
        push(8, -64, 0);
        push(8, 63, 1);
        pulse_start(t0);
        get_req("t2r1", t1);
        check("t2_latency", t1 - t0, 3);
        echo("t2r1");
        get_req("t2r2", t2);
        check("t2_space12", t2 - t1, 3);
        echo("t2r2");
        get_req("t2r3", t3);
        check("t2_space23", t3 - t2, 4);
        echo("t2r3");
        finish_pass("t2", 2);

        // Stop on the cycle a request would be issued.
        pulse_start(t0);
        step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("t4_no_req", next_data_strobe_o, 0);
        check("t4_busy", busy_o, 0);
        check("t4_no_done", done_o, 0);
        repeat (3) begin
            step();
            check("t4_idle_req", next_data_strobe_o, 0);
        end
        start_i = 1'b1;
        stop_i  = 1'b1;
        step();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("t4_both_busy", busy_o, 0);
        repeat (3) begin
            step();
            check("t4_both_req", next_data_strobe_o, 0);
            check("t4_both_idle", busy_o, 0);
        end

        // Generator never answers.
        push(8, -64, 0);
        pulse_start(t0);
        get_req("t3r1", t1);
        repeat (63) step();
        check("t3_err_early", err_o, 0);
        check("t3_busy_early", busy_o, 1);
        step();
        check("t3_err", err_o, 1);
        check("t3_busy", busy_o, 0);
        pulse_start(t0);
        check("t3_err_clr", err_o, 0);
        check("t3_restart_busy", busy_o, 1);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("t3_stop_busy", busy_o, 0);

        // Rewrite segment 1 while segment 0 plays.
        wr(0, 8, 0, 2);
        wr(1, 5, 10, 1);
        div_i = 8'd1;
        push(8, 0, 0);
        push(8, 0, 0);
        pulse_start(t0);
        get_req("t6r1", t1);
        check("t6_latency", t1 - t0, 4);
        echo("t6r1");
        wr(1, -3, 20, 2);
        push(-3, 20, 1);
        push(-3, 20, 1);
        get_req("t6r2", t2);
        check("t6_space", t2 - t1, 4);
        echo("t6r2");
        get_req("t6r3", t3);
        echo("t6r3");
        get_req("t6r4", t3);
        echo("t6r4");
        finish_pass("t6", 2);

        // Reset while waiting for the generator.
        push(8, 0, 0);
        pulse_start(t0);
        get_req("t6rst", t1);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst2_phase", phase_o, 0);
        check("rst2_amp", amplitude_o, 0);
        check("rst2_seg", seg_idx_o, 0);
        check("rst2_req", next_data_strobe_o, 0);
        check("rst2_busy", busy_o, 0);
        check("rst2_done", done_o, 0);
        check("rst2_err", err_o, 0);
        step();
        empty_pass("cleared");

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
